rank_order_encoder: RTL

//  Rank-order (time-to-first-spike) encoder for the SNN input stage. Captures an

---
 rtl/rank_order_encoder.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/rank_order_encoder.sv
// Rank-order (time-to-first-spike) encoder: streams captured pixel indexes in
// decreasing intensity order (ties by ascending index) over a valid/ready port.
module rank_order_encoder #(
    parameter int unsigned IMAGE_SIZE      = 784,
    parameter int unsigned PIXEL_MAX_VALUE = 255,
    parameter int unsigned PIXEL_BITS      = $clog2(PIXEL_MAX_VALUE + 1),
    parameter int unsigned IDX_BITS        = $clog2(IMAGE_SIZE),
    parameter int unsigned CNT_BITS        = $clog2(IMAGE_SIZE + 1)
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [PIXEL_BITS-1:0] image [0:IMAGE_SIZE-1],
    input  logic                  start,
    input  logic                  abort,
    input  logic [PIXEL_BITS-1:0] cfg_threshold,
    input  logic [CNT_BITS-1:0]   cfg_max_spikes,
    output logic [IDX_BITS-1:0]   out_index,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_BITS-1:0]   spike_count
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SCAN = 2'd1;
    localparam logic [1:0] EMIT = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [PIXEL_BITS-1:0] PMAX     = PIXEL_BITS'(PIXEL_MAX_VALUE);
    localparam logic [IDX_BITS-1:0]   LAST_IDX = IDX_BITS'(IMAGE_SIZE - 1);
    localparam logic [CNT_BITS-1:0]   FULL_CNT = CNT_BITS'(IMAGE_SIZE);

    logic [1:0]            state_q, state_d;
    logic [PIXEL_BITS-1:0] pix_q [0:IMAGE_SIZE-1];
    logic [PIXEL_BITS-1:0] image_c [0:IMAGE_SIZE-1];
    logic [PIXEL_BITS-1:0] intensity_q, intensity_d;
    logic [PIXEL_BITS-1:0] thr_q, thr_d;
    logic [CNT_BITS-1:0]   budget_q, budget_d;
    logic [IDX_BITS-1:0]   pixel_id_q, pixel_id_d;
    logic [IDX_BITS-1:0]   out_index_d;
    logic                  out_valid_d, busy_d, done_d;
    logic [CNT_BITS-1:0]   spike_count_d;
    logic                  capture_c;

    // Saturate out-of-range pixels; skipped when the pixel width cannot exceed the maximum
    for (genvar i = 0; i < IMAGE_SIZE; i++) begin : g_clamp
        if (PIXEL_MAX_VALUE + 1 < (1 << PIXEL_BITS)) begin : g_sat
            assign image_c[i] = (image[i] > PMAX) ? PMAX : image[i];
        end else begin : g_pass
            assign image_c[i] = image[i];
        end
    end

    logic                  last_pix_c, last_level_c, exhausted_c, match_c;
    logic [IDX_BITS-1:0]   adv_pixel_c;
    logic [PIXEL_BITS-1:0] adv_intensity_c;
    logic [CNT_BITS-1:0]   count_inc_c;

    // Scan cursor advance; the last level is the threshold level or zero (no underflow)
    always_comb begin
        last_pix_c      = (pixel_id_q == LAST_IDX);
        last_level_c    = (intensity_q <= thr_q) || (intensity_q == '0);
        exhausted_c     = last_pix_c && last_level_c;
        adv_pixel_c     = last_pix_c ? '0 : pixel_id_q + IDX_BITS'(1);
        adv_intensity_c = (last_pix_c && !last_level_c) ? intensity_q - PIXEL_BITS'(1)
                                                        : intensity_q;
        match_c         = (pix_q[pixel_id_q] == intensity_q) && (intensity_q >= thr_q);
        count_inc_c     = spike_count + CNT_BITS'(1);
    end

    always_comb begin
        state_d       = state_q;
        intensity_d   = intensity_q;
        thr_d         = thr_q;
        budget_d      = budget_q;
        pixel_id_d    = pixel_id_q;
        out_index_d   = out_index;
        out_valid_d   = out_valid;
        busy_d        = busy;
        done_d        = 1'b0;
        spike_count_d = spike_count;
        capture_c     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    capture_c     = 1'b1;
                    state_d       = SCAN;
                    busy_d        = 1'b1;
                    intensity_d   = PMAX;
                    pixel_id_d    = '0;
                    spike_count_d = '0;
                    thr_d         = cfg_threshold;
                    budget_d      = (cfg_max_spikes == '0) ? FULL_CNT : cfg_max_spikes;
                end
            end
            SCAN: begin
                if (abort) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                end else if (match_c) begin
                    state_d     = EMIT;
                    out_index_d = pixel_id_q;
                    out_valid_d = 1'b1;
                end else begin
                    pixel_id_d  = adv_pixel_c;
                    intensity_d = adv_intensity_c;
                    if (exhausted_c) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            EMIT: begin
                // abort wins over a same-cycle handshake, which then is not counted
                if (abort) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                end else if (out_ready) begin
                    spike_count_d = count_inc_c;
                    out_valid_d   = 1'b0;
                    pixel_id_d    = adv_pixel_c;
                    intensity_d   = adv_intensity_c;
                    if ((count_inc_c == budget_q) || (count_inc_c == FULL_CNT) || exhausted_c) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = SCAN;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            intensity_q <= '0;
            thr_q       <= '0;
            budget_q    <= '0;
            pixel_id_q  <= '0;
            out_index   <= '0;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            spike_count <= '0;
        end else begin
            state_q     <= state_d;
            intensity_q <= intensity_d;
            thr_q       <= thr_d;
            budget_q    <= budget_d;
            pixel_id_q  <= pixel_id_d;
            out_index   <= out_index_d;
            out_valid   <= out_valid_d;
            busy        <= busy_d;
            done        <= done_d;
            spike_count <= spike_count_d;
        end
    end

    // Image snapshot taken on an accepted start; input may change freely afterwards
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < IMAGE_SIZE; i++) pix_q[i] <= '0;
        end else if (capture_c) begin
            for (int i = 0; i < IMAGE_SIZE; i++) pix_q[i] <= image_c[i];
        end
    end

endmodule
